controller_fsm: RTL and testbench
=================================

CONTROLLER_FSM -- requirements
Module: controller_fsm

Interface
REQ-001 The block SHALL expose parameter NSEL_RN, default 3'b000, meaning the nsel code that selects register field Rn (bits 10:8).
REQ-002 The block SHALL expose parameter NSEL_RD, default 3'b001, meaning the nsel code that selects register field Rd (bits 7:5).
REQ-003 The block SHALL expose parameter NSEL_RM, default 3'b010, meaning the nsel code that selects register field Rm (bits 2:0).
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 s  in  1  start strobe; accepted only in WAIT.
REQ-007 opcode  in  3  instruction bits 15:13 from the decoder.
REQ-008 op  in  2  instruction bits 12:11 from the decoder.
REQ-009 w  out  1  high only in WAIT (idle, ready for s).
REQ-010 nsel  out  3  register-field select to the decoder.
REQ-011 loada, loadb, loadc, loads  out  1 each  datapath register load enables.
REQ-012 asel, bsel  out  1 each  asel=1 forces ALU operand A to zero; bsel=1 selects sximm5.
REQ-013 vsel  out  2  writeback source: 2'b00 = datapath C, 2'b10 = sximm8.
REQ-014 write  out  1  register-file write enable.
REQ-015 err  out  1  sticky illegal-instruction flag.

Function
REQ-016 States SHALL be WAIT, DECODE, WRITE_IMM, GET_A, GET_B, ALU, WRITE_REG, and all outputs SHALL be Moore: a function of the state register and latched instruction fields only.
REQ-017 On a clk edge in WAIT with s=1, the FSM SHALL latch opcode/op internally, clear err, and go to DECODE; s=0 holds WAIT; s in any other state is ignored.
REQ-018 DECODE SHALL branch on the latched fields:
- 110/10 (MOV imm) -> WRITE_IMM.
- 110/00 (MOV reg) and 101/11 (MVN) -> GET_B.
- 101/00, 101/01, 101/10 (ADD, CMP, AND) -> GET_A.
- Any other code -> WAIT with err set to 1.
REQ-019 WRITE_IMM SHALL drive nsel=NSEL_RN, vsel=2'b10, write=1, then go to WAIT.
REQ-020 GET_A SHALL drive nsel=NSEL_RN, loada=1, then go to GET_B.
REQ-021 GET_B SHALL drive nsel=NSEL_RM, loadb=1, then go to ALU.
REQ-022 ALU SHALL drive bsel=0 and asel=1 for MOV reg and MVN, otherwise asel=0.
- CMP: loads=1, loadc=0, next state WAIT.
- All other instructions: loadc=1, loads=0, next state WRITE_REG.
REQ-023 WRITE_REG SHALL drive nsel=NSEL_RD, vsel=2'b00, write=1, then go to WAIT.
REQ-024 In any state, outputs not named for that state SHALL be 0; nsel SHALL be NSEL_RN when not otherwise specified.
REQ-025 Cycles from s accepted to return to WAIT SHALL be:
- MOV imm: 2.
- CMP: 4.
- MOV reg and MVN: 4.
- ADD and AND: 5.
REQ-026 Each strobe (loada, loadb, loadc, loads, write) SHALL be high for exactly one cycle per instruction.
REQ-027 Changes on opcode/op after s is accepted SHALL NOT affect the sequence.
REQ-028 Unreachable state encodings SHALL recover to WAIT on the next edge with all strobes 0.

Reset
REQ-029 While reset_n=0, asynchronously and regardless of clk:
- state=WAIT, w=1, err=0.
- All strobes, asel, bsel =0; vsel=2'b00; nsel=NSEL_RN; latched fields =0.
REQ-030 A reset asserted mid-instruction SHALL abort it immediately, with no further write or load pulse.
REQ-031 After reset_n rises, the FSM SHALL accept s on the first clk edge.

Verification
REQ-032 Reset then s=1, opcode=110, op=10 -> DECODE; next cycle WRITE_IMM with nsel=000, vsel=10, write=1; next cycle w=1.
REQ-033 s=1, opcode=101, op=00 (ADD) -> states in order DECODE, GET_A (loada, nsel=000), GET_B (loadb, nsel=010), ALU (loadc, asel=0), WRITE_REG (write, nsel=001, vsel=00); w=1 on the 6th edge.
REQ-034 CMP 101/01 -> ALU cycle has loads=1 and loadc=0; write never asserts; w=1 after 4 cycles.
REQ-035 MVN 101/11 -> GET_A skipped, asel=1 in ALU, write in WRITE_REG; opcode toggled to 000 during execution has no effect.
REQ-036 Illegal opcode 111 -> DECODE then WAIT with err=1 and no strobes; a following valid s clears err.
REQ-037 Pull reset_n low during GET_B of an ADD -> immediately w=1 and all strobes 0; no write occurs.

Source files
------------

// File: rtl/controller_fsm.sv
// Instruction-sequencing controller: walks one decoded instruction through
// register read, ALU and writeback, producing Moore-style datapath controls.
module controller_fsm #(
  parameter logic [2:0] NSEL_RN = 3'b000,
  parameter logic [2:0] NSEL_RD = 3'b001,
  parameter logic [2:0] NSEL_RM = 3'b010
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       s,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic       w,
  output logic [2:0] nsel,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic [1:0] vsel,
  output logic       write,
  output logic       err,
  output logic [2:0] o_dbg_state
);

  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_WRITE_IMM = 3'd2,
    S_GET_A     = 3'd3,
    S_GET_B     = 3'd4,
    S_ALU       = 3'd5,
    S_WRITE_REG = 3'd6
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [2:0] r_opcode;
  logic [1:0] r_op;
  logic       r_err;

  logic w_accept;
  logic w_mov_imm;
  logic w_unary;
  logic w_binary;
  logic w_cmp;
  logic w_illegal;

  assign w_accept  = (r_state == S_WAIT) && s;
  assign w_mov_imm = (r_opcode == 3'b110) && (r_op == 2'b10);
  // MOV reg and MVN pass only Rm through the ALU, so operand A is forced to zero.
  assign w_unary   = ((r_opcode == 3'b110) && (r_op == 2'b00)) ||
                     ((r_opcode == 3'b101) && (r_op == 2'b11));
  assign w_binary  = (r_opcode == 3'b101) && (r_op != 2'b11);
  assign w_cmp     = (r_opcode == 3'b101) && (r_op == 2'b01);
  assign w_illegal = !(w_mov_imm || w_unary || w_binary);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_WAIT;
    else          r_state <= w_next;
  end

  // Instruction fields are captured once so later decoder changes cannot disturb the sequence.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_opcode <= 3'b000;
      r_op     <= 2'b00;
      r_err    <= 1'b0;
    end else if (w_accept) begin
      r_opcode <= opcode;
      r_op     <= op;
      r_err    <= 1'b0;
    end else if ((r_state == S_DECODE) && w_illegal) begin
      r_err    <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = S_WAIT;
    case (r_state)
      S_WAIT:      w_next = s ? S_DECODE : S_WAIT;
      S_DECODE: begin
        if (w_mov_imm)     w_next = S_WRITE_IMM;
        else if (w_unary)  w_next = S_GET_B;
        else if (w_binary) w_next = S_GET_A;
        else               w_next = S_WAIT;
      end
      S_WRITE_IMM: w_next = S_WAIT;
      S_GET_A:     w_next = S_GET_B;
      S_GET_B:     w_next = S_ALU;
      S_ALU:       w_next = w_cmp ? S_WAIT : S_WRITE_REG;
      S_WRITE_REG: w_next = S_WAIT;
      default:     w_next = S_WAIT;
    endcase
  end

  // Output logic
  always_comb begin
    w     = 1'b0;
    nsel  = NSEL_RN;
    loada = 1'b0;
    loadb = 1'b0;
    loadc = 1'b0;
    loads = 1'b0;
    asel  = 1'b0;
    bsel  = 1'b0;
    vsel  = 2'b00;
    write = 1'b0;
    case (r_state)
      S_WAIT: w = 1'b1;
      S_WRITE_IMM: begin
        nsel  = NSEL_RN;
        vsel  = 2'b10;
        write = 1'b1;
      end
      S_GET_A: begin
        nsel  = NSEL_RN;
        loada = 1'b1;
      end
      S_GET_B: begin
        nsel  = NSEL_RM;
        loadb = 1'b1;
      end
      S_ALU: begin
        asel  = w_unary;
        loads = w_cmp;
        loadc = !w_cmp;
      end
      S_WRITE_REG: begin
        nsel  = NSEL_RD;
        vsel  = 2'b00;
        write = 1'b1;
      end
      default: ;
    endcase
  end

  assign err         = r_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_controller_fsm.sv
// Bench for controller_fsm: expected per-cycle control vectors are queued when
// an instruction is issued and compared cycle by cycle as the FSM advances.
module tb_controller_fsm;

  localparam logic [2:0] RN = 3'b000;
  localparam logic [2:0] RD = 3'b001;
  localparam logic [2:0] RM = 3'b010;

  localparam logic [2:0] ST_WAIT = 3'd0, ST_DECODE = 3'd1, ST_WIMM = 3'd2,
                         ST_GET_A = 3'd3, ST_GET_B = 3'd4, ST_ALU = 3'd5,
                         ST_WREG = 3'd6;

  logic       clk;
  logic       reset_n;
  logic       s;
  logic [2:0] opcode;
  logic [1:0] op;
  logic       w, loada, loadb, loadc, loads, asel, bsel, write, err;
  logic [2:0] nsel;
  logic [1:0] vsel;
  logic [2:0] dbg_state;

  int checks   = 0;
  int failures = 0;
  bit model_err = 1'b0;

  logic [16:0] exp_q[$];
  logic [16:0] act_vec;

  controller_fsm #(.NSEL_RN(RN), .NSEL_RD(RD), .NSEL_RM(RM)) dut (
    .clk(clk), .reset_n(reset_n), .s(s), .opcode(opcode), .op(op),
    .w(w), .nsel(nsel), .loada(loada), .loadb(loadb), .loadc(loadc),
    .loads(loads), .asel(asel), .bsel(bsel), .vsel(vsel), .write(write),
    .err(err), .o_dbg_state(dbg_state)
  );

  // {w, err, nsel, loada, loadb, loadc, loads, asel, bsel, vsel, write, state}
  assign act_vec = {w, err, nsel, loada, loadb, loadc, loads, asel, bsel, vsel, write, dbg_state};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] model(input logic [2:0] st, input bit is_cmp,
                                        input bit unary, input bit e);
    logic       mw, ma, mb, mc, ms, mas, mwr;
    logic [2:0] mn;
    logic [1:0] mv;
    mw = 0; ma = 0; mb = 0; mc = 0; ms = 0; mas = 0; mwr = 0; mn = RN; mv = 2'b00;
    case (st)
      ST_WAIT:  mw = 1;
      ST_WIMM:  begin mv = 2'b10; mwr = 1; end
      ST_GET_A: ma = 1;
      ST_GET_B: begin mn = RM; mb = 1; end
      ST_ALU:   begin mas = unary; if (is_cmp) ms = 1; else mc = 1; end
      ST_WREG:  begin mn = RD; mwr = 1; end
      default:  ;
    endcase
    return {mw, e, mn, ma, mb, mc, ms, mas, 1'b0, mv, mwr, st};
  endfunction

  // Queue the full expected trace of one instruction, ending in WAIT.
  task automatic push_seq(input logic [2:0] opc, input logic [1:0] o);
    bit mov_imm, unary, binary, is_cmp;
    mov_imm = (opc == 3'b110) && (o == 2'b10);
    unary   = ((opc == 3'b110) && (o == 2'b00)) || ((opc == 3'b101) && (o == 2'b11));
    binary  = (opc == 3'b101) && (o != 2'b11);
    is_cmp  = (opc == 3'b101) && (o == 2'b01);
    exp_q.push_back(model(ST_DECODE, 0, 0, 0));
    if (mov_imm) begin
      exp_q.push_back(model(ST_WIMM, 0, 0, 0));
    end else if (unary || binary) begin
      if (binary) exp_q.push_back(model(ST_GET_A, 0, 0, 0));
      exp_q.push_back(model(ST_GET_B, 0, 0, 0));
      exp_q.push_back(model(ST_ALU, is_cmp, unary, 0));
      if (!is_cmp) exp_q.push_back(model(ST_WREG, 0, 0, 0));
    end
    model_err = !(mov_imm || unary || binary);
    exp_q.push_back(model(ST_WAIT, 0, 0, model_err));
  endtask

  task automatic drain(input string name, input bit toggle, input bit hold_s);
    logic [16:0] exp;
    int cyc;
    cyc = 0;
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      if (!hold_s) s = 1'b0;
      if (toggle) begin opcode = 3'b000; op = 2'b00; end
      exp = exp_q.pop_front();
      cyc++;
      checks++;
      if (act_vec !== exp) begin
        failures++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act_vec, exp);
      end
    end
    s = 1'b0;
  endtask

  task automatic run_instr(input string name, input logic [2:0] opc, input logic [1:0] o,
                           input bit toggle, input bit hold_s);
    s = 1'b1; opcode = opc; op = o;
    push_seq(opc, o);
    drain(name, toggle, hold_s);
  endtask

  task automatic test_reset();
    reset_n = 1'b1; s = 1'b0; opcode = 3'b000; op = 2'b00;
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (act_vec !== model(ST_WAIT, 0, 0, 0)) begin
      failures++;
      $display("FAIL reset_async: got %h expected %h", act_vec, model(ST_WAIT, 0, 0, 0));
    end
    s = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (act_vec !== model(ST_WAIT, 0, 0, 0)) begin
      failures++;
      $display("FAIL reset_hold: got %h expected %h", act_vec, model(ST_WAIT, 0, 0, 0));
    end
    s = 1'b0;
    reset_n = 1'b1;
    model_err = 1'b0;
  endtask

  task automatic test_idle(input string name);
    s = 1'b0;
    repeat (3) exp_q.push_back(model(ST_WAIT, 0, 0, model_err));
    drain(name, 0, 0);
  endtask

  task automatic test_reset_mid();
    s = 1'b1; opcode = 3'b101; op = 2'b00;
    exp_q.push_back(model(ST_DECODE, 0, 0, 0));
    exp_q.push_back(model(ST_GET_A, 0, 0, 0));
    exp_q.push_back(model(ST_GET_B, 0, 0, 0));
    drain("reset_mid_pre", 0, 0);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (act_vec !== model(ST_WAIT, 0, 0, 0)) begin
      failures++;
      $display("FAIL reset_mid_abort: got %h expected %h", act_vec, model(ST_WAIT, 0, 0, 0));
    end
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (act_vec !== model(ST_WAIT, 0, 0, 0)) begin
        failures++;
        $display("FAIL reset_mid_nowrite: got %h expected %h", act_vec, model(ST_WAIT, 0, 0, 0));
      end
    end
    reset_n = 1'b1;
    model_err = 1'b0;
  endtask

  task automatic test_random();
    logic [2:0] opc;
    logic [1:0] o;
    for (int i = 0; i < 16; i++) begin
      opc = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) opc = 3'($urandom_range(5, 6));
      o = 2'($urandom_range(0, 3));
      run_instr("random", opc, o, 0, 0);
      if ($urandom_range(0, 1) == 1) test_idle("random_idle");
    end
  endtask

  initial begin
    test_reset();
    run_instr("mov_imm_after_reset", 3'b110, 2'b10, 0, 0);
    test_idle("idle_hold");
    run_instr("add", 3'b101, 2'b00, 0, 0);
    run_instr("cmp", 3'b101, 2'b01, 0, 0);
    run_instr("and", 3'b101, 2'b10, 0, 0);
    run_instr("mvn_toggle", 3'b101, 2'b11, 1, 0);
    run_instr("mov_reg", 3'b110, 2'b00, 0, 0);
    run_instr("illegal_111", 3'b111, 2'b00, 0, 0);
    test_idle("err_sticky");
    run_instr("err_clear", 3'b110, 2'b10, 0, 0);
    run_instr("illegal_110_01", 3'b110, 2'b01, 0, 0);
    run_instr("add_s_held", 3'b101, 2'b00, 0, 1);
    run_instr("back_to_back", 3'b101, 2'b01, 0, 0);
    test_reset_mid();
    run_instr("first_edge_after_reset", 3'b101, 2'b10, 0, 0);
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
